// File: rtl/event_encoder_8to3.sv
// Registered 8-to-3 event encoder.
// Rising edges on req are captured into a pending register and drained one
// index at a time over a valid/ready stream.
// Build option: define EVENT_ENCODER_ROUND_ROBIN_EN to use round-robin selection
// (scan upward from the last loaded index). Otherwise the highest pending index wins.
module event_encoder_8to3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] out_idx,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] pending,
    output logic       overflow
);

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    logic       state, state_nxt;
    logic [7:0] req_q;
    logic [7:0] rise;
    logic       any_pend;
    logic       load;
    logic [2:0] sel_idx;
    logic [7:0] load_mask;

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    logic [2:0] last;
`endif

    assign rise      = req & ~req_q;
    assign any_pend  = |pending;
    // A load happens whenever there is work and the output slot is free or draining.
    assign load      = any_pend && ((state == ST_EMPTY) || out_ready);
    assign out_valid = (state == ST_FULL);

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    // Round-robin pick: first pending bit at last+1, last+2, ... (wrapping), last itself last.
    always_comb begin
        sel_idx = last;
        for (int k = 8; k >= 1; k--) begin
            if (pending[last + 3'(k)]) sel_idx = last + 3'(k);
        end
    end
`else
    // Fixed priority pick: the highest set pending bit wins.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i]) sel_idx = 3'(i);
        end
    end
`endif

    // One-hot of the index consumed from pending this edge.
    always_comb begin
        load_mask = 8'b0;
        if (load) load_mask[sel_idx] = 1'b1;
    end

    // Output FSM: EMPTY waits for work; FULL holds until accepted, then reloads or empties.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (any_pend) state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !any_pend) state_nxt = ST_EMPTY;
            default:  state_nxt = ST_EMPTY;
        endcase
    end

    // Edge capture, pending bookkeeping (a new rise beats a same-edge clear), overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= 8'b0;
            pending  <= 8'b0;
            overflow <= 1'b0;
        end else begin
            req_q    <= req;
            pending  <= (pending & ~load_mask) | rise;
            overflow <= |(rise & pending & ~load_mask);
        end
    end

    // State and output index; out_idx only moves on a load so it is stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_EMPTY;
            out_idx <= 3'd0;
        end else begin
            state <= state_nxt;
            if (load) out_idx <= sel_idx;
        end
    end

`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
    // Remember the most recent load; reset value 7 makes the first scan start at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last <= 3'd7;
        else if (load) last <= sel_idx;
    end
`endif

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Scoreboard bench for event_encoder_8to3: a behavioural model predicts each
// loaded index into a queue, and a monitor pops it at every handshake.
module tb_event_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;
    int sbq[$];

    // model state
    bit [7:0] m_prev;
    bit       m_pend[8];
    bit       m_valid;
    int       m_idx;
    int       m_last;
    bit       m_ov;

    event_encoder_8to3 dut (
        .clk(clk), .rst(rst), .req(req), .out_idx(out_idx), .out_valid(out_valid),
        .out_ready(out_ready), .pending(pending), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 8'h00;
        for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_idx = 0;
        m_last = 7;
        m_ov = 1'b0;
    endtask

    // Predict the state after the next clock edge given the inputs held for it.
    task automatic model_step(input bit [7:0] r, input bit rdy);
        bit rise[8];
        bit any;
        bit ld;
        int sel;
        any = 1'b0;
        sel = -1;
        for (int i = 0; i < 8; i++) begin
            rise[i] = r[i] && !m_prev[i];
            any = any || m_pend[i];
        end
`ifdef EVENT_ENCODER_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            if (sel < 0 && m_pend[(m_last + k) % 8]) sel = (m_last + k) % 8;
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (sel < 0 && m_pend[i]) sel = i;
        end
`endif
        ld = any && (!m_valid || rdy);
        m_ov = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rise[i] && m_pend[i] && !(ld && sel == i)) m_ov = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            m_pend[i] = (m_pend[i] && !(ld && sel == i)) || rise[i];
        end
        m_valid = ld || (m_valid && !rdy);
        if (ld) begin
            m_idx = sel;
            m_last = sel;
            sbq.push_back(sel);
        end
        m_prev = r;
    endtask

    function automatic int pend_val();
        int v = 0;
        for (int i = 0; i < 8; i++) if (m_pend[i]) v += (1 << i);
        return v;
    endfunction

    // One cycle: drive inputs, advance the model, then compare after the edge.
    task automatic cyc(input bit [7:0] r, input bit rdy);
        req = r;
        out_ready = rdy;
        model_step(r, rdy);
        @(posedge clk);
        #1;
        chk("pending", int'(pending), pend_val());
        chk("overflow", int'(overflow), int'(m_ov));
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("out_idx", int'(out_idx), m_idx);
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, release after an edge.
    task automatic do_reset(input bit [7:0] r);
        req = r;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_overflow", int'(overflow), 0);
        sbq.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: a handshake is in progress when valid and ready are both high mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL handshake: got idx %0d expected none queued at %0t", out_idx, $time);
            end else begin
                chk("handshake_idx", int'(out_idx), sbq.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = 8'h00;
        out_ready = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_out_idx", int'(out_idx), 0);
        chk("reset_overflow", int'(overflow), 0);
        rst = 1'b0;

        // single event held high
        repeat (4) cyc(8'h20, 1'b1);
        repeat (2) cyc(8'h00, 1'b1);
        // simultaneous events
        repeat (5) cyc(8'h91, 1'b1);
        repeat (2) cyc(8'h00, 1'b1);
        // backpressure
        repeat (5) cyc(8'h0C, 1'b0);
        repeat (3) cyc(8'h0C, 1'b1);
        repeat (2) cyc(8'h00, 1'b1);
        // overflow on a stalled pending bit, then set-wins on the loading bit
        cyc(8'h00, 1'b0);
        repeat (3) cyc(8'h0C, 1'b0);
        cyc(8'h08, 1'b0);
        cyc(8'h0C, 1'b0);
        cyc(8'h08, 1'b0);
        cyc(8'h0C, 1'b1);
        repeat (4) cyc(8'h00, 1'b1);
        // reset while valid with pending = F0
        repeat (3) cyc(8'h01, 1'b0);
        cyc(8'hF1, 1'b0);
        do_reset(8'h00);
        repeat (3) cyc(8'h00, 1'b1);
        // all lines high from reset, then 81
        do_reset(8'hFF);
        repeat (10) cyc(8'hFF, 1'b1);
        repeat (2) cyc(8'h00, 1'b1);
        repeat (4) cyc(8'h81, 1'b1);
        repeat (3) cyc(8'h00, 1'b1);
        // random traffic
        for (int n = 0; n < 2000; n++) begin
            cyc(8'($urandom), $urandom_range(0, 3) != 0);
        end
        repeat (12) cyc(8'h00, 1'b1);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
